// File: rtl/greenflow_pkg.sv
// Shared types and helpers for the greenflow slot scheduler.
// Status encoding follows the greenflow_gate status_code output.
package greenflow_pkg;

    localparam logic [1:0] ST_GREEN  = 2'b00;
    localparam logic [1:0] ST_YELLOW = 2'b01;
    localparam logic [1:0] ST_RED    = 2'b10;
    localparam logic [1:0] ST_RSVD   = 2'b11;

    localparam int GF_KW_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REPORT,
        S_DWELL,
        S_LOCKOUT
    } gf_state_e;

    // The reserved code is treated as a red verdict.
    function automatic logic is_red(input logic [1:0] status);
        return (status == ST_RED) || (status == ST_RSVD);
    endfunction

endpackage

// File: rtl/greenflow_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr_i,
// wrapping modulo NUM_REQ.
module greenflow_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_i} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!any_o && req_valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/greenflow_slot_scheduler.sv
// Time-slot scheduler sharing one greenflow_gate among NUM_REQ requesters.
// Define GREENFLOW_FAULT_LOCK_EN to enable the red-verdict LOCKOUT state and fault counter.
module greenflow_slot_scheduler
    import greenflow_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int KW_W        = GF_KW_W,
    parameter int SETTLE_CYC  = 2,
    parameter int DWELL_CYC   = 1000,
    parameter int FAULT_LIMIT = 3,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*KW_W-1:0] req_kw,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    gate_valid,
    output logic [KW_W-1:0]         gate_kw,
    input  logic [KW_W-1:0]         gate_power,
    input  logic [1:0]              gate_status,
    output logic                    grant_valid,
    output logic [ID_W-1:0]         grant_id,
    output logic [KW_W-1:0]         grant_kw,
    output logic [1:0]              grant_status,
    output logic                    fault_lockout,
    input  logic                    clear_fault
);

    localparam int CNT_MAX = (DWELL_CYC > SETTLE_CYC) ? DWELL_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    gf_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [KW_W-1:0]   kw_q, kw_d;
    logic              gate_valid_q, gate_on_d;
    logic [KW_W-1:0]   gate_kw_q;
    logic              grant_valid_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [KW_W-1:0]   grant_kw_q;
    logic [1:0]        grant_status_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    greenflow_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (arb_grant),
        .idx_o       (arb_idx),
        .any_o       (arb_any)
    );

`ifdef GREENFLOW_FAULT_LOCK_EN
    localparam int FC_W = $clog2(FAULT_LIMIT + 1);
    logic [FC_W-1:0] fault_cnt_q, fault_cnt_d;
    logic            lockout_q;
`else
    logic unused_clear;
    assign unused_clear = clear_fault;
`endif

    // req_ready is the only combinational output; held low while rst is asserted.
    assign req_ready = (state_q == S_IDLE && !rst) ? arb_grant : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        kw_d     = kw_q;
`ifdef GREENFLOW_FAULT_LOCK_EN
        fault_cnt_d = fault_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    id_d     = arb_idx;
                    kw_d     = req_kw[int'(arb_idx)*KW_W +: KW_W];
                    rr_ptr_d = (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC-1)) begin
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                cnt_d = '0;
`ifdef GREENFLOW_FAULT_LOCK_EN
                if (is_red(grant_status_q)) begin
                    if (fault_cnt_q >= FC_W'(FAULT_LIMIT-1)) begin
                        fault_cnt_d = FC_W'(FAULT_LIMIT);
                        state_d     = S_LOCKOUT;
                    end else begin
                        fault_cnt_d = fault_cnt_q + 1'b1;
                        state_d     = S_DWELL;
                    end
                end else begin
                    fault_cnt_d = '0;
                    state_d     = S_DWELL;
                end
`else
                state_d = is_red(grant_status_q) ? S_IDLE : S_DWELL;
`endif
            end
            S_DWELL: begin
                if (cnt_q == CNT_W'(DWELL_CYC-1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOCKOUT: begin
`ifdef GREENFLOW_FAULT_LOCK_EN
                if (clear_fault) begin
                    fault_cnt_d = '0;
                    state_d     = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gate_on_d = (state_d == S_SETTLE) || (state_d == S_REPORT) || (state_d == S_DWELL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            rr_ptr_q       <= '0;
            gate_valid_q   <= 1'b0;
            gate_kw_q      <= '0;
            grant_valid_q  <= 1'b0;
            grant_id_q     <= '0;
            grant_kw_q     <= '0;
            grant_status_q <= ST_GREEN;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            gate_valid_q  <= gate_on_d;
            gate_kw_q     <= gate_on_d ? kw_d : '0;
            grant_valid_q <= (state_d == S_REPORT);
            // Gate result is captured on the last settle cycle.
            if (state_q == S_SETTLE && state_d == S_REPORT) begin
                grant_id_q     <= id_q;
                grant_kw_q     <= gate_power;
                grant_status_q <= gate_status;
            end
        end
    end

    always_ff @(posedge clk) begin
        id_q <= id_d;
        kw_q <= kw_d;
    end

`ifdef GREENFLOW_FAULT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt_q <= '0;
            lockout_q   <= 1'b0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
            lockout_q   <= (state_d == S_LOCKOUT);
        end
    end
    assign fault_lockout = lockout_q;
`else
    assign fault_lockout = 1'b0;
`endif

    assign gate_valid   = gate_valid_q;
    assign gate_kw      = gate_kw_q;
    assign grant_valid  = grant_valid_q;
    assign grant_id     = grant_id_q;
    assign grant_kw     = grant_kw_q;
    assign grant_status = grant_status_q;

endmodule

// File: tb/tb_greenflow_slot_scheduler.sv
// Bench for greenflow_slot_scheduler: timeline model checked every cycle plus directed literal checks.
// Honours GREENFLOW_FAULT_LOCK_EN the same way as the design.
module tb_greenflow_slot_scheduler;

    localparam int NR = 4;
    localparam int KW = 16;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int FL = 3;
`ifdef GREENFLOW_FAULT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*KW-1:0] req_kw;
    logic [NR-1:0]   req_ready;
    logic            gate_valid;
    logic [KW-1:0]   gate_kw;
    logic [KW-1:0]   gate_power;
    logic [1:0]      gate_status;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic [KW-1:0]   grant_kw;
    logic [1:0]      grant_status;
    logic            fault_lockout;
    logic            clear_fault;

    logic [KW-1:0]   pw_tab [16];
    logic [1:0]      st_tab [16];

    greenflow_slot_scheduler #(
        .NUM_REQ     (NR),
        .KW_W        (KW),
        .SETTLE_CYC  (S),
        .DWELL_CYC   (D),
        .FAULT_LIMIT (FL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_kw        (req_kw),
        .req_ready     (req_ready),
        .gate_valid    (gate_valid),
        .gate_kw       (gate_kw),
        .gate_power    (gate_power),
        .gate_status   (gate_status),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .grant_kw      (grant_kw),
        .grant_status  (grant_status),
        .fault_lockout (fault_lockout),
        .clear_fault   (clear_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit run      = 1'b0;

    // Model state: one slot timeline at a time.
    bit            busy, locked, lock_pend;
    int            t0, s_end, rr, fcnt, nslots, cur_slot, s_id;
    logic [KW-1:0] s_kw;
    logic [1:0]    g_id;
    logic [KW-1:0] g_kw;
    logic [1:0]    g_st;
    int            rel, w;
    logic [NR-1:0] e_rdy;
    logic          e_gv, e_grv;
    logic [KW-1:0] e_gkw;

    assign gate_power  = pw_tab[cur_slot[3:0]];
    assign gate_status = st_tab[cur_slot[3:0]];

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h cycle=%0d", nm, got, exp, cyc);
    endfunction

    function automatic int pick(input logic [NR-1:0] v, input int p);
        int j;
        for (int k = 0; k < NR; k++) begin
            j = (p + k) % NR;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        busy = 0; locked = 0; lock_pend = 0; rr = 0; fcnt = 0; nslots = 0; cur_slot = 0;
        t0 = 0; s_end = 0; s_id = 0; s_kw = '0; g_id = '0; g_kw = '0; g_st = '0;
    endtask

    always @(negedge clk) begin
        if (run) begin
            rel   = cyc - t0;
            e_rdy = '0;
            e_gv  = 1'b0;
            e_gkw = '0;
            e_grv = 1'b0;
            w     = -1;
            if (!locked && !busy) begin
                w = pick(req_valid, rr);
                if (w >= 0 && !rst) e_rdy = NR'(1) << w;
            end
            if (busy && rel >= 1) begin
                e_gv  = 1'b1;
                e_gkw = s_kw;
            end
            if (busy && rel == S + 1) e_grv = 1'b1;
            chk("m_req_ready",    32'(req_ready),     32'(e_rdy));
            chk("m_gate_valid",   32'(gate_valid),    32'(e_gv));
            chk("m_gate_kw",      32'(gate_kw),       32'(e_gkw));
            chk("m_grant_valid",  32'(grant_valid),   32'(e_grv));
            chk("m_grant_id",     32'(grant_id),      32'(g_id));
            chk("m_grant_kw",     32'(grant_kw),      32'(g_kw));
            chk("m_grant_status", 32'(grant_status),  32'(g_st));
            chk("m_fault_lockout",32'(fault_lockout), 32'(locked));
            if (rst) begin
                model_reset();
            end else if (locked) begin
                if (clear_fault) begin
                    locked = 0;
                    fcnt   = 0;
                end
            end else if (!busy) begin
                if (w >= 0) begin
                    busy      = 1;
                    t0        = cyc;
                    s_id      = w;
                    s_kw      = req_kw[w*KW +: KW];
                    rr        = (w + 1) % NR;
                    cur_slot  = nslots;
                    nslots    = nslots + 1;
                    s_end     = cyc + 1000;
                    lock_pend = 0;
                end
            end else begin
                if (rel == S) begin
                    g_id  = s_id[1:0];
                    g_kw  = gate_power;
                    g_st  = gate_status;
                    s_end = t0 + S + D + 2;
                    if (gate_status[1]) begin
                        if (LOCK_EN) begin
                            fcnt = (fcnt + 1 > FL) ? FL : fcnt + 1;
                            if (fcnt == FL) begin
                                lock_pend = 1;
                                s_end     = t0 + S + 2;
                            end
                        end else begin
                            s_end = t0 + S + 2;
                        end
                    end else begin
                        fcnt = 0;
                    end
                end
                if (cyc + 1 == s_end) begin
                    busy = 0;
                    if (lock_pend) locked = 1;
                end
            end
            cyc++;
        end
    end

    int now_rel;

    task automatic go(input int r);
        while (now_rel < r) begin
            @(posedge clk); #1;
            now_rel++;
        end
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic test_start();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; clear_fault = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        now_rel = 0;
    endtask

    int gcount;

    initial begin
        rst = 1'b1; req_valid = '0; clear_fault = 1'b0;
        req_kw = '0;
        for (int i = 0; i < 16; i++) begin pw_tab[i] = '0; st_tab[i] = 2'b00; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        samp();
        chk("rst_gate_valid",   32'(gate_valid),    32'd0);
        chk("rst_grant_id",     32'(grant_id),      32'd0);
        chk("rst_grant_kw",     32'(grant_kw),      32'd0);
        chk("rst_req_ready",    32'(req_ready),     32'd0);
        chk("rst_fault_lockout",32'(fault_lockout), 32'd0);

        // Single requester 1, yellow clamp.
        test_start();
        pw_tab[0] = 16'd450; st_tab[0] = 2'b01;
        req_kw[1*KW +: KW] = 16'd500;
        req_valid = 4'b0010;
        samp();
        chk("t1_ready0", 32'(req_ready), 32'h2);
        go(1); req_valid = '0; samp();
        chk("t1_gv1", 32'(gate_valid), 32'd1);
        chk("t1_gkw1", 32'(gate_kw), 32'd500);
        go(3); samp();
        chk("t1_grv3", 32'(grant_valid), 32'd1);
        chk("t1_gid3", 32'(grant_id), 32'd1);
        chk("t1_gkw3", 32'(grant_kw), 32'd450);
        chk("t1_gst3", 32'(grant_status), 32'd1);
        go(7); samp();
        chk("t1_gv7", 32'(gate_valid), 32'd1);
        go(8); samp();
        chk("t1_gv8", 32'(gate_valid), 32'd0);

        // Requesters 0, 2, 3 contend: round-robin 0,2,3,0.
        test_start();
        for (int i = 0; i < 16; i++) begin pw_tab[i] = 16'(1000 + i); st_tab[i] = 2'b00; end
        req_kw[0*KW +: KW] = 16'd100;
        req_kw[2*KW +: KW] = 16'd300;
        req_kw[3*KW +: KW] = 16'd400;
        req_valid = 4'b1101;
        go(3); samp();
        chk("t2_grv3", 32'(grant_valid), 32'd1);
        chk("t2_gid3", 32'(grant_id), 32'd0);
        go(8); samp();
        chk("t2_gap8", 32'(gate_valid), 32'd0);
        go(9); samp();
        chk("t2_gkw9", 32'(gate_kw), 32'd300);
        go(11); samp();
        chk("t2_gid11", 32'(grant_id), 32'd2);
        chk("t2_gkw11", 32'(grant_kw), 32'd1001);
        go(19); samp();
        chk("t2_gid19", 32'(grant_id), 32'd3);
        go(27); samp();
        chk("t2_grv27", 32'(grant_valid), 32'd1);
        chk("t2_gid27", 32'(grant_id), 32'd0);
        go(28); req_valid = '0;

        // Three red slots in a row.
        test_start();
        for (int i = 0; i < 16; i++) begin pw_tab[i] = 16'd0; st_tab[i] = 2'b10; end
        pw_tab[3] = 16'd777; st_tab[3] = 2'b00;
        req_valid = 4'b0001;
        go(3); samp();
        chk("t3_gv3", 32'(gate_valid), 32'd1);
        chk("t3_gst3", 32'(grant_status), 32'd2);
`ifdef GREENFLOW_FAULT_LOCK_EN
        go(20); samp();
        chk("t3_lock20", 32'(fault_lockout), 32'd1);
        chk("t3_gv20", 32'(gate_valid), 32'd0);
        chk("t3_gkw20", 32'(gate_kw), 32'd0);
        chk("t3_rdy20", 32'(req_ready), 32'd0);
        go(22); clear_fault = 1'b1;
        go(23); clear_fault = 1'b0; samp();
        chk("t3_lock23", 32'(fault_lockout), 32'd0);
        chk("t3_rdy23", 32'(req_ready), 32'h1);
        go(24); req_valid = '0;
        go(26); samp();
        chk("t3_grv26", 32'(grant_valid), 32'd1);
        chk("t3_gkw26", 32'(grant_kw), 32'd777);
        chk("t3_gst26", 32'(grant_status), 32'd0);
`else
        go(4); samp();
        chk("t3_gv4", 32'(gate_valid), 32'd0);
        chk("t3_rdy4", 32'(req_ready), 32'h1);
        go(7); samp();
        chk("t3_grv7", 32'(grant_valid), 32'd1);
        go(20); samp();
        chk("t3_lock20", 32'(fault_lockout), 32'd0);
        go(22); clear_fault = 1'b1;
        go(23); clear_fault = 1'b0; req_valid = '0;
`endif

        // Red, red, green, red, red: the green clears the fault count.
        test_start();
        for (int i = 0; i < 16; i++) begin
            pw_tab[i] = 16'(200 + i);
            st_tab[i] = (i == 2 || i >= 5) ? 2'b00 : 2'b10;
        end
        req_valid = 4'b0001;
        gcount = 0;
        for (int r = 0; r < 40; r++) begin
            go(r); samp();
            if (grant_valid) gcount++;
        end
`ifdef GREENFLOW_FAULT_LOCK_EN
        chk("t4_grants", 32'(gcount), 32'd5);
`else
        chk("t4_grants", 32'(gcount), 32'd7);
`endif
        chk("t4_nolock", 32'(fault_lockout), 32'd0);
        go(40); req_valid = '0;

        // Reset in the middle of a slot.
        test_start();
        for (int i = 0; i < 16; i++) begin pw_tab[i] = 16'd50; st_tab[i] = 2'b00; end
        req_valid = 4'b0010;
        go(2); rst = 1'b1; req_valid = 4'b0101;
        go(3); rst = 1'b0; samp();
        chk("t5_gv3", 32'(gate_valid), 32'd0);
        chk("t5_grv3", 32'(grant_valid), 32'd0);
        chk("t5_rdy3", 32'(req_ready), 32'h1);
        go(4); req_valid = '0; samp();
        chk("t5_gkw4", 32'(gate_kw), 32'd100);

        go(16);
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
